// File: rtl/ahb_gpio_seq_arbiter.sv
// AHB-Lite single-master front end for the AHBGPIO slave.
// Two clients arbitrate round-robin for one register access at a time. The
// winner is driven as a NONSEQ address phase followed by a data phase, with
// HREADYOUT wait states honoured. The bus outputs are registered.
module ahb_gpio_seq_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
    parameter logic [7:0]  DATA_OFF  = 8'h00,
    parameter logic [7:0]  DIR_OFF   = 8'h04,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              sel0,
    input  logic              sel1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              HSEL,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic              HREADY,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADYOUT,
    input  logic              PARITYERR,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic                sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                hsel_q, hsel_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                hwrite_q, hwrite_d;
    logic [31:0]         haddr_q, haddr_d;
    logic [31:0]         hwdata_q, hwdata_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;

    // Winner of the current IDLE arbitration and its request fields
    logic                grant_n;
    logic                we_n;
    logic                sel_n;

    // Only the low DATA_W bits of HRDATA carry GPIO data
    logic                unused_hrdata;
    assign unused_hrdata = ^HRDATA;

    // Next-state, bus-output and client-response computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        sel_d        = sel_q;
        wdata_d      = wdata_q;
        hsel_d       = hsel_q;
        htrans_d     = htrans_q;
        hwrite_d     = hwrite_q;
        haddr_d      = haddr_q;
        hwdata_d     = hwdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err_count_d  = err_count_q;
        grant_n      = (req0 && req1) ? ~last_grant_q : req1;
        we_n         = grant_n ? we1  : we0;
        sel_n        = grant_n ? sel1 : sel0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d      = grant_n;
                    last_grant_d = grant_n;
                    we_d         = we_n;
                    sel_d        = sel_n;
                    wdata_d      = grant_n ? wdata1 : wdata0;
                    hsel_d       = 1'b1;
                    htrans_d     = 2'b10;
                    hwrite_d     = we_n;
                    haddr_d      = BASE_ADDR + 32'(sel_n ? DIR_OFF : DATA_OFF);
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADYOUT) begin
                    hsel_d   = 1'b0;
                    htrans_d = 2'b00;
                    hwdata_d = we_q ? 32'(wdata_q) : '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADYOUT) begin
                    hwdata_d = '0;
                    state_d  = ST_RESP;
                    if (grant_q) begin
                        ack1_d = 1'b1;
                        err1_d = PARITYERR;
                        if (!we_q) rdata1_d = HRDATA[DATA_W-1:0];
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = PARITYERR;
                        if (!we_q) rdata0_d = HRDATA[DATA_W-1:0];
                    end
                    if (PARITYERR && (err_count_q != '1))
                        err_count_d = err_count_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 1'b0;
            wdata_q      <= '0;
            hsel_q       <= 1'b0;
            htrans_q     <= 2'b00;
            hwrite_q     <= 1'b0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            wdata_q      <= wdata_d;
            hsel_q       <= hsel_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            haddr_q      <= haddr_d;
            hwdata_q     <= hwdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err_count_q  <= err_count_d;
        end
    end

    assign HSEL      = hsel_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HREADY    = HREADYOUT;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign err_count = err_count_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_gpio_seq_arbiter.sv
// Directed bench for ahb_gpio_seq_arbiter. Stimulus pushes the expected
// client response into a scoreboard queue; a monitor pops and compares on
// every ack. Bus-side phase checks are made inline by the stimulus process.
module tb_ahb_gpio_seq_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req0, req1, we0, we1, sel0, sel1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic        HSEL, HWRITE, HREADY, busy;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HREADYOUT, PARITYERR;
    logic [7:0]  err_count;

    typedef struct {
        logic        client;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_cnt;

    ahb_gpio_seq_arbiter #(
        .DATA_W   (16),
        .BASE_ADDR(32'h5000_0000),
        .DATA_OFF (8'h00),
        .DIR_OFF  (8'h04),
        .CNT_W    (8)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .sel0(sel0), .sel1(sel1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .PARITYERR(PARITYERR),
        .busy(busy), .err_count(err_count)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic c, input logic [15:0] rd, input logic e);
        exp_t x;
        x.client = c;
        x.rdata  = rd;
        x.err    = e;
        sb.push_back(x);
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge HCLK) begin
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_pair", {30'd0, ack1, ack0}, e.client ? 32'd2 : 32'd1);
                if (e.client) begin
                    check("rdata1", {16'd0, rdata1}, {16'd0, e.rdata});
                    check("err1", {31'd0, err1}, {31'd0, e.err});
                end else begin
                    check("rdata0", {16'd0, rdata0}, {16'd0, e.rdata});
                    check("err0", {31'd0, err0}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; sel0 = 0; sel1 = 0;
        wdata0 = '0; wdata1 = '0;
        HRDATA = '0; HREADYOUT = 1'b1; PARITYERR = 1'b0;
        #1;
        check("rst_hsel", {31'd0, HSEL}, 32'd0);
        check("rst_htrans", {30'd0, HTRANS}, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        check("rst_rdata", {rdata1, rdata0}, 32'd0);
        check("rst_errcnt", {24'd0, err_count}, 32'd0);
        check("hready_loop", {31'd0, HREADY}, 32'd1);
        tick(); tick();
        HRESETn = 1'b1;
        tick();

        // Client 0 writes 0x00FF to the direction register, zero wait
        req0 = 1; we0 = 1; sel0 = 1; wdata0 = 16'h00FF;
        push(1'b0, 16'h0000, 1'b0);
        tick();
        req0 = 0;
        check("t1_haddr", HADDR, 32'h5000_0004);
        check("t1_htrans", {30'd0, HTRANS}, 32'd2);
        check("t1_hwrite", {31'd0, HWRITE}, 32'd1);
        check("t1_hsel", {31'd0, HSEL}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1_hwdata", HWDATA, 32'h0000_00FF);
        check("t1_data_hsel", {31'd0, HSEL}, 32'd0);
        check("t1_data_htrans", {30'd0, HTRANS}, 32'd0);
        check("t1_data_haddr", HADDR, 32'h5000_0004);
        tick();
        check("t1_ack0", {31'd0, ack0}, 32'd1);
        tick();
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_ack0", {31'd0, ack0}, 32'd0);
        check("t1_idle_haddr", HADDR, 32'h5000_0004);

        // Client 1 reads the data register; upper HRDATA bits are discarded
        req1 = 1; we1 = 0; sel1 = 0; HRDATA = 32'hDEAD_A5A5;
        push(1'b1, 16'hA5A5, 1'b0);
        tick();
        req1 = 0;
        check("t2_haddr", HADDR, 32'h5000_0000);
        check("t2_hwrite", {31'd0, HWRITE}, 32'd0);
        tick();
        check("t2_hwdata_rd", HWDATA, 32'd0);
        tick();
        check("t2_ack1", {31'd0, ack1}, 32'd1);
        tick();

        // Both clients held high: grants alternate 0,1,0,1, one per 4 cycles
        req0 = 1; we0 = 1; sel0 = 0; wdata0 = 16'h1111;
        req1 = 1; we1 = 0; sel1 = 1; HRDATA = 32'h0000_5A5A;
        for (int k = 0; k < 4; k++) begin
            push(k[0], k[0] ? 16'h5A5A : 16'h0000, 1'b0);
            tick();
            check("rr_haddr", HADDR, k[0] ? 32'h5000_0004 : 32'h5000_0000);
            check("rr_hwrite", {31'd0, HWRITE}, k[0] ? 32'd0 : 32'd1);
            tick();
            tick();
            check("rr_ack", {30'd0, ack1, ack0}, k[0] ? 32'd2 : 32'd1);
            if (k == 3) begin
                req0 = 0;
                req1 = 0;
            end
            tick();
        end
        tick();
        check("rr_quiet", {31'd0, busy}, 32'd0);

        // Three wait states in the data phase
        req0 = 1; we0 = 1; sel0 = 0; wdata0 = 16'hBEEF;
        push(1'b0, 16'h0000, 1'b0);
        tick();
        req0 = 0;
        tick();
        HREADYOUT = 1'b0;
        check("ws_hwdata0", HWDATA, 32'h0000_BEEF);
        for (int w = 0; w < 3; w++) begin
            tick();
            check("ws_hwdata", HWDATA, 32'h0000_BEEF);
            check("ws_busy", {31'd0, busy}, 32'd1);
            check("ws_noack", {31'd0, ack0}, 32'd0);
        end
        HREADYOUT = 1'b1;
        tick();
        check("ws_ack0", {31'd0, ack0}, 32'd1);
        tick();

        // 300 reads with parity error at completion; counter saturates
        check("pe_cnt_start", {24'd0, err_count}, 32'd0);
        PARITYERR = 1'b1; HRDATA = 32'h0000_0F0F;
        we0 = 0; sel0 = 0;
        for (int n = 1; n <= 300; n++) begin
            req0 = 1;
            push(1'b0, 16'h0F0F, 1'b1);
            tick();
            req0 = 0;
            tick();
            tick();
            tick();
            exp_cnt = (n > 255) ? 255 : n;
            check("pe_count", {24'd0, err_count}, exp_cnt);
        end
        PARITYERR = 1'b0;

        // Reset during the data phase abandons the transfer without an ack
        req1 = 1; we1 = 1; sel1 = 1; wdata1 = 16'h7777;
        tick();
        req1 = 0;
        tick();
        check("mr_in_data", HWDATA, 32'h0000_7777);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mr_hsel", {31'd0, HSEL}, 32'd0);
        check("mr_hwdata", HWDATA, 32'd0);
        check("mr_haddr", HADDR, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_errcnt", {24'd0, err_count}, 32'd0);
        check("mr_rdata0", {16'd0, rdata0}, 32'd0);
        tick();
        HRESETn = 1'b1;
        tick();
        req1 = 1; we1 = 0; sel1 = 0; HRDATA = 32'h0000_C3C3;
        push(1'b1, 16'hC3C3, 1'b0);
        tick();
        req1 = 0;
        check("mr2_haddr", HADDR, 32'h5000_0000);
        tick();
        tick();
        check("mr2_ack1", {31'd0, ack1}, 32'd1);
        tick();

        // Drain: every expected response must have been seen
        for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_gpio_seq_arbiter.md
Name: ahb_gpio_seq_arbiter

Overview:
- AHB-Lite single-master front end for the AHBGPIO slave. Two client ports can each ask for one register write or read at a time.
- Round-robin arbitration between the clients; the winning request is sequenced into a NONSEQ address phase followed by a data phase, honouring HREADYOUT wait states.
- Returns read data and a per-transfer parity-error flag to the client, and keeps a saturating parity-error count.
- Sits between the software/test clients and AHBGPIO; its AHB outputs connect directly to the GPIO slave ports.

Parameters:
- DATA_W, 16, GPIO data width; client wdata/rdata width; HWDATA zero-extended to 32.
- BASE_ADDR, 32'h5000_0000, GPIO slave base address.
- DATA_OFF, 8'h00, offset of the GPIO data register.
- DIR_OFF, 8'h04, offset of the GPIO direction register.
- CNT_W, 8, width of the parity-error counter.

Ports:
- HCLK  in  1  clock, all logic on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- req0 / req1  in  1  client request; held high until ack.
- we0 / we1  in  1  1 = write, 0 = read.
- sel0 / sel1  in  1  0 = data register, 1 = direction register.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  read result, valid with ack.
- err0 / err1  out  1  PARITYERR seen at completion, valid with ack.
- HSEL  out  1  slave select.
- HADDR  out  32  address.
- HTRANS  out  2  transfer type.
- HWRITE  out  1  direction.
- HREADY  out  1  equals HREADYOUT (combinational loop-back for single-slave bus).
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADYOUT  in  1  slave ready.
- PARITYERR  in  1  slave parity error.
- busy  out  1  high whenever state is not IDLE.
- err_count  out  CNT_W  saturating parity-error count.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - State returns to IDLE and the transfer is abandoned with no ack.
  - HSEL=0, HTRANS=2'b00, HWRITE=0, HADDR=0, HWDATA=0.
  - ack*/err*/busy=0, rdata*=0, err_count=0.
  - last_grant=1, so client 0 wins first.
- IDLE:
  - If any req is high at an edge, grant and latch we/sel/wdata of the winner, then go to ADDR.
  - Both requesting: grant the client that is not last_grant, and update last_grant.
  - Only one requesting: grant it regardless of last_grant.
- ADDR (bus address phase):
  - HSEL=1, HTRANS=2'b10, HWRITE=latched we.
  - HADDR = BASE_ADDR + (sel ? DIR_OFF : DATA_OFF).
  - Leave for DATA at the edge where HREADYOUT=1; otherwise hold all outputs stable.
- DATA (bus data phase):
  - HSEL=0, HTRANS=2'b00; HADDR/HWRITE keep their ADDR values.
  - HWDATA = zero-extended latched wdata on a write, 0 on a read.
  - At the edge with HREADYOUT=1:
    - Capture HRDATA[DATA_W-1:0] on a read; rdata is unchanged on a write.
    - Capture PARITYERR.
    - Go to RESP.
  - HREADYOUT=0 extends DATA indefinitely.
- RESP:
  - Granted client's ack=1 for exactly one cycle; err shows the captured PARITYERR.
  - rdata holds until that client's next read completes.
  - Next state is IDLE.
- err_count: increments at the DATA completion edge when PARITYERR=1 and saturates at all-ones.
- Zero-wait latency:
  - req sampled at edge E0; ADDR runs E0–E1, DATA E1–E2, ack high E2–E3.
  - One transfer per 4 cycles at most.
- Request handling:
  - A request dropped before grant is ignored.
  - After grant the transfer always completes and acks, even if req drops.
  - The ungranted client's req stays pending and is served in the next IDLE.
  - A client holding req high through its ack cycle is re-arbitrated as a new request in IDLE.
- HADDR/HWRITE hold their last value in IDLE and RESP.

Test Plan:
- Reset, then req0=1, we0=1, sel0=1, wdata0=16'h00FF with zero wait → HADDR=32'h5000_0004, HTRANS=2'b10, HWRITE=1 in cycle 1; HWDATA=32'h0000_00FF in cycle 2; ack0 in cycle 3, err0=0.
- req1 read of the data register, GPIOIN=16'hA5A5 → HADDR=32'h5000_0000, HWRITE=0; rdata1=16'hA5A5 with ack1 three cycles after the request.
- req0 and req1 both high, held continuously for 4 transfers → grant order 0,1,0,1; acks spaced 4 cycles apart.
- Slave holds HREADYOUT=0 for 3 cycles in the data phase → HWDATA stable, ack delayed by exactly 3 cycles; busy=1 throughout.
- Force PARITYERR=1 at completion on 300 transfers → each ack carries err=1; err_count saturates at 8'hFF.
- HRESETn pulsed low during DATA → outputs zero immediately, no ack; a subsequent req1 completes normally.
